// File: rtl/vga_vu_bars.sv
// VGA timing generator with an N-channel VU-meter bar renderer, RGB332 pixels.
// All outputs registered one cycle behind (h,v); free-running, no backpressure (level_valid is a capture strobe).
module vga_vu_bars #(
    parameter int         THADDR     = 640,
    parameter int         THFP       = 16,
    parameter int         THS        = 96,
    parameter int         THBP       = 48,
    parameter int         TVADDR     = 480,
    parameter int         TVFP       = 10,
    parameter int         TVS        = 2,
    parameter int         TVBP       = 33,
    parameter bit         H_POL      = 1'b0,
    parameter bit         V_POL      = 1'b0,
    parameter int         C_SIZE     = 10,
    parameter int         N_CH       = 2,
    parameter int         LVL_W      = 8,
    parameter int         BAR_GAP    = 32,
    parameter int         YEL_X      = 384,
    parameter int         RED_X      = 512,
    parameter int         PEAK_HOLD  = 30,
    parameter int         PEAK_DECAY = 4,
    parameter int         PEAK_W     = 2,
    parameter logic [7:0] BG         = 8'h00
) (
    input  logic                    pixel_clock,
    input  logic                    reset,
    input  logic [N_CH*LVL_W-1:0]   level,
    input  logic                    level_valid,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic [2:0]              red,
    output logic [2:0]              green,
    output logic [1:0]              blue,
    output logic                    de,
    output logic                    frame_start
);

    localparam int HT     = THADDR + THFP + THS + THBP;
    localparam int VT     = TVADDR + TVFP + TVS + TVBP;
    localparam int BAR_H  = (TVADDR - (N_CH + 1) * BAR_GAP) / N_CH;
    localparam int HOLD_W = (PEAK_HOLD > 1) ? $clog2(PEAK_HOLD + 1) : 1;
    localparam int PROD_W = LVL_W + C_SIZE;

    typedef logic [C_SIZE-1:0] cnt_t;

    localparam cnt_t       H_LAST  = cnt_t'(HT - 1);
    localparam cnt_t       V_LAST  = cnt_t'(VT - 1);
    localparam cnt_t       DECAY   = cnt_t'(PEAK_DECAY);
    localparam logic [7:0] C_GREEN = {3'd3, 3'd7, 2'd0};
    localparam logic [7:0] C_YEL   = {3'd7, 3'd7, 2'd0};
    localparam logic [7:0] C_RED   = {3'd7, 3'd0, 2'd0};
    localparam logic [7:0] C_WHITE = 8'hFF;

    cnt_t                h;
    cnt_t                v;
    logic                frame_load;

    logic [LVL_W-1:0]    shadow  [N_CH];
    cnt_t                bar_len [N_CH];
    cnt_t                peak    [N_CH];
    logic [HOLD_W-1:0]   hold    [N_CH];
    cnt_t                len     [N_CH];
    cnt_t                decayed [N_CH];

    logic                hs_act;
    logic                vs_act;
    logic                active;
    logic [7:0]          pix;

    assign frame_load = (h == H_LAST) && (v == V_LAST);

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Scaled length uses the full-width product so the shift never sees a truncated value.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            len[c]     = cnt_t'((PROD_W'(shadow[c]) * PROD_W'(THADDR)) >> LVL_W);
            decayed[c] = (peak[c] > DECAY) ? peak[c] - DECAY : '0;
        end
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                shadow[c]  <= '0;
                bar_len[c] <= '0;
                peak[c]    <= '0;
                hold[c]    <= '0;
            end
        end else begin
            if (level_valid) begin
                for (int c = 0; c < N_CH; c++) begin
                    shadow[c] <= level[c*LVL_W +: LVL_W];
                end
            end
            if (frame_load) begin
                for (int c = 0; c < N_CH; c++) begin
                    bar_len[c] <= len[c];
                    if (len[c] >= peak[c]) begin
                        peak[c] <= len[c];
                        hold[c] <= HOLD_W'(PEAK_HOLD);
                    end else if (hold[c] != '0) begin
                        hold[c] <= hold[c] - 1'b1;
                    end else begin
                        peak[c] <= (len[c] > decayed[c]) ? len[c] : decayed[c];
                    end
                end
            end
        end
    end

    always_comb begin
        int  hi;
        int  vi;
        int  band_top;
        int  sel_len;
        int  sel_peak;
        logic in_band;

        hi       = int'(h);
        vi       = int'(v);
        band_top = 0;
        sel_len  = 0;
        sel_peak = 0;
        in_band  = 1'b0;

        hs_act = (hi >= THADDR + THFP) && (hi < THADDR + THFP + THS);
        vs_act = (vi >= TVADDR + TVFP) && (vi < TVADDR + TVFP + TVS);
        active = (hi < THADDR) && (vi < TVADDR);

        for (int c = 0; c < N_CH; c++) begin
            band_top = BAR_GAP + c * (BAR_H + BAR_GAP);
            if (vi >= band_top && vi < band_top + BAR_H) begin
                in_band  = 1'b1;
                sel_len  = int'(bar_len[c]);
                sel_peak = int'(peak[c]);
            end
        end

        pix = BG;
        if (in_band) begin
            // Peak marker is drawn over the bar and takes precedence.
            if (sel_peak >= PEAK_W && hi >= sel_peak - PEAK_W && hi < sel_peak) begin
                pix = C_WHITE;
            end else if (hi < sel_len) begin
                if (hi < YEL_X) begin
                    pix = C_GREEN;
                end else if (hi < RED_X) begin
                    pix = C_YEL;
                end else begin
                    pix = C_RED;
                end
            end
        end
        if (!active) begin
            pix = 8'h00;
        end
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_sync               <= hs_act ? H_POL : ~H_POL;
            v_sync               <= vs_act ? V_POL : ~V_POL;
            {red, green, blue}   <= pix;
            de                   <= active;
            frame_start          <= (h == '0) && (v == '0);
        end
    end

endmodule

// File: tb/tb_vga_vu_bars.sv
// Scoreboard bench for vga_vu_bars on a reduced 40x28 frame (32x24 active, two bars).
// Expected pixels are queued by output index; the monitor pops and compares them as pixels emerge.
module tb_vga_vu_bars;

    localparam int HT = 40;
    localparam int FT = 40 * 28;

    typedef struct packed {
        logic signed [63:0] idx;
        logic [95:0]        nm;
        logic [7:0]         rgb;
        logic               de;
        logic               hs;
        logic               vs;
        logic               fs;
    } exp_t;

    logic        pixel_clock = 1'b0;
    logic        reset;
    logic [15:0] level;
    logic        level_valid;
    logic        h_sync;
    logic        v_sync;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
    logic        de;
    logic        frame_start;

    exp_t        q[$];
    exp_t        mon_e;
    longint      out_idx = 0;
    int          cur = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cnt_hs = 0;
    int          cnt_vs = 0;
    int          cnt_de = 0;
    int          cnt_fs = 0;
    bit          agg_done = 1'b0;
    bit          done = 1'b0;

    vga_vu_bars #(
        .THADDR(32), .THFP(2), .THS(4), .THBP(2),
        .TVADDR(24), .TVFP(1), .TVS(2), .TVBP(1),
        .H_POL(1'b0), .V_POL(1'b0), .C_SIZE(6), .N_CH(2), .LVL_W(8),
        .BAR_GAP(2), .YEL_X(16), .RED_X(24),
        .PEAK_HOLD(3), .PEAK_DECAY(4), .PEAK_W(2), .BG(8'h00)
    ) dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .level       (level),
        .level_valid (level_valid),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .de          (de),
        .frame_start (frame_start)
    );

    always #5 pixel_clock = ~pixel_clock;

    function automatic exp_t mk(input logic [95:0] nm, input int f, input int x, input int y,
                                input logic [7:0] rgb);
        exp_t e;
        e.idx = 64'(f) * FT + 64'(y * HT + x);
        e.nm  = nm;
        e.rgb = rgb;
        e.de  = (x < 32) && (y < 24);
        e.hs  = !((x >= 34) && (x < 38));
        e.vs  = !((y >= 25) && (y < 27));
        e.fs  = (x == 0) && (y == 0);
        return e;
    endfunction

    function automatic exp_t mk_rst(input logic [95:0] nm);
        exp_t e;
        e.idx = -64'sd1;
        e.nm  = nm;
        e.rgb = 8'h00;
        e.de  = 1'b0;
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        e.fs  = 1'b0;
        return e;
    endfunction

    task automatic push(input exp_t e);
        int i;
        i = q.size();
        while (i > 0 && q[i-1].idx > e.idx) i--;
        q.insert(i, e);
    endtask

    task automatic goto(input int k);
        while (cur < k) begin
            @(negedge pixel_clock);
            cur++;
        end
    endtask

    task automatic check(input exp_t e);
        logic [11:0] act;
        logic [11:0] req;
        act = {red, green, blue, de, h_sync, v_sync, frame_start};
        req = {e.rgb, e.de, e.hs, e.vs, e.fs};
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s idx=%0d: got rgb=%h de,hs,vs,fs=%b, want rgb=%h de,hs,vs,fs=%b",
                     e.nm, e.idx, act[11:4], act[3:0], req[11:4], req[3:0]);
        end
    endtask

    task automatic check_cnt(input logic [95:0] nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    always @(negedge pixel_clock) begin
        if (reset) begin
            out_idx = 0;
            if (q.size() > 0 && q[0].idx < 0) begin
                mon_e = q.pop_front();
                check(mon_e);
            end
        end else begin
            if (!agg_done && out_idx == 64'(2 * FT)) begin
                check_cnt("t1_hs_low", cnt_hs, 4 * 28 * 2);
                check_cnt("t1_vs_low", cnt_vs, 2 * 40 * 2);
                check_cnt("t1_de_high", cnt_de, 32 * 24 * 2);
                check_cnt("t1_fs_cnt", cnt_fs, 2);
                agg_done = 1'b1;
            end
            if (!agg_done) begin
                cnt_hs += int'(!h_sync);
                cnt_vs += int'(!v_sync);
                cnt_de += int'(de);
                cnt_fs += int'(frame_start);
            end
            while (q.size() > 0 && q[0].idx < out_idx) begin
                mon_e = q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL %s idx=%0d: expectation never reached, got no sample", mon_e.nm, mon_e.idx);
            end
            while (q.size() > 0 && q[0].idx == out_idx) begin
                mon_e = q.pop_front();
                check(mon_e);
            end
            out_idx++;
        end
        if (done) begin
            while (q.size() > 0) begin
                mon_e = q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL %s idx=%0d: left unchecked at end, got no sample", mon_e.nm, mon_e.idx);
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        level       = '0;
        level_valid = 1'b0;
        #1 reset = 1'b1;
        push(mk_rst("rst_init"));

        // Frame 0 timing and empty bars
        push(mk("t1_fs",      0,  0,  0, 8'h00));
        push(mk("t1_fs_off",  0,  1,  0, 8'h00));
        push(mk("t1_de_last", 0, 31,  0, 8'h00));
        push(mk("t1_de_off",  0, 32,  0, 8'h00));
        push(mk("t1_hs_pre",  0, 33,  0, 8'h00));
        push(mk("t1_hs_on",   0, 34,  0, 8'h00));
        push(mk("t1_hs_last", 0, 37,  0, 8'h00));
        push(mk("t1_hs_off",  0, 38,  0, 8'h00));
        push(mk("t1_row23",   0,  0, 23, 8'h00));
        push(mk("t1_row24",   0,  0, 24, 8'h00));
        push(mk("t1_vs_on",   0,  0, 25, 8'h00));
        push(mk("t1_vs_last", 0, 39, 26, 8'h00));
        push(mk("t1_vs_off",  0,  0, 27, 8'h00));
        push(mk("t1_f1_fs",   1,  0,  0, 8'h00));

        // ch0 = 0x80 -> length 16, peak marker at 14..15
        push(mk("t2_old0",    0,  0,  2, 8'h00));
        push(mk("t2_old14",   0, 14,  2, 8'h00));
        push(mk("t2_grn0",    1,  0,  2, 8'h7C));
        push(mk("t2_grn13",   1, 13,  2, 8'h7C));
        push(mk("t2_pk14",    1, 14,  2, 8'hFF));
        push(mk("t2_pk15",    1, 15,  2, 8'hFF));
        push(mk("t2_bg16",    1, 16,  2, 8'h00));
        push(mk("t2_lastrow", 1,  0, 10, 8'h7C));
        push(mk("t2_gap",     1,  0, 11, 8'h00));
        push(mk("t2_ch1",     1,  5, 13, 8'h00));

        // ch1 = 0xFF -> length 31: green/yellow/red split, marker at 29..30
        push(mk("t3_top",     2,  0, 12, 8'h00));
        push(mk("t3_g15",     2, 15, 13, 8'h7C));
        push(mk("t3_y16",     2, 16, 13, 8'hFC));
        push(mk("t3_y23",     2, 23, 13, 8'hFC));
        push(mk("t3_r24",     2, 24, 13, 8'hE0));
        push(mk("t3_r28",     2, 28, 13, 8'hE0));
        push(mk("t3_pk29",    2, 29, 13, 8'hFF));
        push(mk("t3_pk30",    2, 30, 13, 8'hFF));
        push(mk("t3_bg31",    2, 31, 13, 8'h00));
        push(mk("t3_row21",   2,  0, 21, 8'h7C));
        push(mk("t3_row22",   2,  0, 22, 8'h00));
        push(mk("t3_ch0",     2, 14, 10, 8'hFF));

        // ch0 0xFF then 0x00: peak 31 held frames 3..6, then 27,23,...,3,0
        push(mk("t4_f3_g",    3,  0,  2, 8'h7C));
        push(mk("t4_f3_r",    3, 24,  2, 8'hE0));
        push(mk("t4_f3_pk",   3, 30,  2, 8'hFF));
        push(mk("t4_ch1",     3, 30, 13, 8'hFF));
        push(mk("t4_f4_bar",  4,  0,  2, 8'h00));
        push(mk("t4_f4_28",   4, 28,  2, 8'h00));
        push(mk("t4_f4_pk",   4, 29,  2, 8'hFF));
        push(mk("t4_f6_pk",   6, 30,  2, 8'hFF));
        push(mk("t4_f7_pk",   7, 25,  2, 8'hFF));
        push(mk("t4_f7_26",   7, 26,  2, 8'hFF));
        push(mk("t4_f7_27",   7, 27,  2, 8'h00));
        push(mk("t4_f7_29",   7, 29,  2, 8'h00));
        push(mk("t4_f8_pk",   8, 21,  2, 8'hFF));
        push(mk("t4_f8_23",   8, 23,  2, 8'h00));
        push(mk("t4_f13_0",  13,  0,  2, 8'h00));
        push(mk("t4_f13_1",  13,  1,  2, 8'hFF));
        push(mk("t4_f13_2",  13,  2,  2, 8'hFF));
        push(mk("t4_f13_3",  13,  3,  2, 8'h00));
        push(mk("t4_f14_1",  14,  1,  2, 8'h00));
        push(mk("t4_f14_2",  14,  2,  2, 8'h00));

        // ch0 = 0x40 strobed on the frame-15 load edge: frame 15 old, frame 16 length 8
        push(mk("t5_old0",   15,  0,  2, 8'h00));
        push(mk("t5_old6",   15,  6,  2, 8'h00));
        push(mk("t5_old7",   15,  7,  2, 8'h00));
        push(mk("t5_new0",   16,  0,  2, 8'h7C));
        push(mk("t5_new5",   16,  5,  2, 8'h7C));
        push(mk("t5_new6",   16,  6,  2, 8'hFF));
        push(mk("t5_new7",   16,  7,  2, 8'hFF));
        push(mk("t5_new8",   16,  8,  2, 8'h00));

        repeat (3) @(negedge pixel_clock);
        #2 reset = 1'b0;
        @(negedge pixel_clock);
        cur = 0;

        goto(20);
        level = {8'h00, 8'h80}; level_valid = 1'b1;
        goto(21);
        level_valid = 1'b0;

        goto(FT + 20);
        level = {8'hFF, 8'h80}; level_valid = 1'b1;
        goto(FT + 21);
        level_valid = 1'b0;

        goto(2 * FT + 20);
        level = {8'hFF, 8'hFF}; level_valid = 1'b1;
        goto(2 * FT + 21);
        level_valid = 1'b0;

        goto(3 * FT + 20);
        level = {8'hFF, 8'h00}; level_valid = 1'b1;
        goto(3 * FT + 21);
        level_valid = 1'b0;

        goto(15 * FT - 2);
        level = {8'hFF, 8'h40}; level_valid = 1'b1;
        goto(15 * FT - 1);
        level_valid = 1'b0;

        // Mid-line reset for 3 clocks
        goto(16 * FT + 200);
        #2 reset = 1'b1;
        push(mk_rst("t6_rst"));
        repeat (3) @(negedge pixel_clock);
        push(mk("t6_fs",      0,  0,  0, 8'h00));
        push(mk("t6_ch0",     0,  0,  2, 8'h00));
        push(mk("t6_pk",      0, 14,  2, 8'h00));
        push(mk("t6_ch1",     0, 30, 13, 8'h00));
        push(mk("t6_de_last", 0, 31,  0, 8'h00));
        push(mk("t6_hs_on",   0, 34,  0, 8'h00));
        push(mk("t6_f1_ch0",  1,  0,  2, 8'h00));
        push(mk("t6_f1_ch1",  1, 29, 13, 8'h00));
        #2 reset = 1'b0;
        @(negedge pixel_clock);
        cur = 0;

        goto(2 * FT);
        done = 1'b1;
        repeat (4) @(negedge pixel_clock);
        $display("FAIL end: monitor did not finish the run");
        $fatal(1, "monitor stalled");
    end

endmodule
